mem_responder: RTL and testbench

Synthesizable memory-side responder for the core's memory interface: it owns a word-organised RAM, holds the core in reset while the RAM is cleared and a program image is streamed in, then releases the core and serves its read and write requests with fixed one-cycle read latency. It sits at the memory end of the core's memory interface, opposite the core. It drives `data_mem_core` and the core's reset, and samples `addr`, `data_core_mem`, `we` and `re`. It replaces the behavioural memory model in simulation and is used on FPGA builds.

---
 rtl/mem_resp_pkg.sv | 19 +
 rtl/mem_resp_ram.sv | 51 +++++
 rtl/mem_responder.sv | 142 ++++++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory responder.
package mem_resp_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_CLEAR   = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } mem_resp_state_e;

  // Byte address to word index. The caller slices the RAM index from the
  // low bits and treats any remaining upper bit as out of range.
  function automatic logic [63:0] word_idx(input logic [63:0] byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/mem_resp_ram.sv
// Single-port word RAM with one write port and a registered read.
// A read and a write to the same word on one edge return the old word.
module mem_resp_ram
  import mem_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int WIDTH      = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic                  we_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic                  rzero_i,
  output logic [WIDTH-1:0]      rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Storage array: no reset, contents are owned by the controller.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read data holds unless a read is issued; a zero-forced read returns 0.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rzero_i ? '0 : mem_q[addr_i];
    end
  end

  // Read data register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: clears the RAM, streams in a program image while
// holding the core in reset, then serves core reads/writes.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_CLEAR   | zero one word per cycle, ptr 0..DEPTH-1
//   ST_LOAD    | accept image beats into word ptr, load_ready=1
//   ST_RELEASE | one extra cycle of core reset with the RAM stable
//   ST_RUN     | core out of reset, serve we/re requests
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [WORD_W-1:0]     load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     data_core_mem,
  input  logic                  we,
  input  logic                  re,
  output logic [WORD_W-1:0]     data_mem_core,
  output logic                  core_rst_n,
  output logic                  err
);

  localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;

  mem_resp_state_e state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic                  err_q, err_d;

  logic [63:0]           widx;
  logic [DEPTH_LOG2-1:0] run_idx;
  logic                  oor;

  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;
  logic [WORD_W-1:0]     ram_wdata;
  logic                  ram_re;
  logic                  ram_rzero;

  // Core address decode: word index from the low bits, range check on the rest.
  assign widx    = word_idx(64'(addr));
  assign run_idx = widx[DEPTH_LOG2-1:0];
  assign oor     = |(widx >> DEPTH_LOG2);

  // Next-state, pointer, error and RAM port mux.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    ram_addr  = ptr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_re    = 1'b0;
    ram_rzero = 1'b0;

    case (state_q)
      ST_CLEAR: begin
        ram_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == PTR_MAX) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ram_wdata = load_data;
        if (load_valid) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          if (load_last || (ptr_q == PTR_MAX)) begin
            state_d = ST_RELEASE;
          end
          // Image ran past the last word without a terminating beat.
          if (!load_last && (ptr_q == PTR_MAX)) begin
            err_d = 1'b1;
          end
        end
      end
      ST_RELEASE: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        ram_addr  = run_idx;
        ram_wdata = data_core_mem;
        ram_we    = we & ~oor;
        ram_re    = re;
        ram_rzero = oor;
        if ((we || re) && oor) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // Nothing reaches the array while the block is held in reset.
    if (!rst_n) begin
      ram_we = 1'b0;
      ram_re = 1'b0;
    end
  end

  // State, pointer and sticky error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  mem_resp_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WORD_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .rzero_i (ram_rzero),
    .rdata_o (data_mem_core)
  );

  // Outputs decode straight from the state register.
  assign load_ready = (state_q == ST_LOAD);
  assign core_rst_n = (state_q == ST_RUN);
  assign err        = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a 16-word RAM.
module tb_mem_responder;

  localparam int AW = 32;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic [AW-1:0] addr;
  logic [31:0]   data_core_mem;
  logic          we;
  logic          re;
  logic [31:0]   data_mem_core;
  logic          core_rst_n;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(AW), .DEPTH_LOG2(DL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .addr          (addr),
    .data_core_mem (data_core_mem),
    .we            (we),
    .re            (re),
    .data_mem_core (data_mem_core),
    .core_rst_n    (core_rst_n),
    .err           (err)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    string       nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!load_ready && n < 40) begin
      step();
      n++;
    end
    chk("wait_load_ready", 32'(load_ready), 32'd1);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    re = 1'b1; we = 1'b0; addr = a;
    step();
    chk(nm, data_mem_core, exp);
    re = 1'b0;
  endtask

  function automatic void add(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] ed,
                              input logic ee, input string nm);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = wd;
    v.exp_data = ed; v.exp_err = ee; v.nm = nm;
    vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //      we    re    addr          wdata         exp_data      err
    add(1'b0, 1'b1, 32'h0,        32'h0,        32'h11,       1'b0, "rd_w0");
    add(1'b0, 1'b1, 32'h4,        32'h0,        32'h22,       1'b0, "rd_w1");
    add(1'b0, 1'b1, 32'h8,        32'h0,        32'h33,       1'b0, "rd_w2");
    add(1'b0, 1'b1, 32'hC,        32'h0,        32'h0,        1'b0, "rd_w3_cleared");
    add(1'b0, 1'b1, 32'h5,        32'h0,        32'h22,       1'b0, "rd_lsb_ignored");
    add(1'b1, 1'b0, 32'h8,        32'hDEADBEEF, 32'h22,       1'b0, "wr_hold");
    add(1'b0, 1'b1, 32'h8,        32'h0,        32'hDEADBEEF, 1'b0, "rd_after_wr");
    add(1'b1, 1'b1, 32'h8,        32'h5,        32'hDEADBEEF, 1'b0, "rd_before_wr");
    add(1'b0, 1'b1, 32'h8,        32'h0,        32'h5,        1'b0, "rd_new");
    add(1'b0, 1'b1, 32'h3C,       32'h0,        32'h0,        1'b0, "rd_top_word");
    add(1'b1, 1'b0, 32'h3C,       32'hA5,       32'h0,        1'b0, "wr_top_word");
    add(1'b0, 1'b1, 32'h3F,       32'h0,        32'hA5,       1'b0, "rd_top_word2");
    add(1'b0, 1'b0, 32'h0,        32'h0,        32'hA5,       1'b0, "idle_hold");
    add(1'b1, 1'b0, 32'h40,       32'h77,       32'hA5,       1'b1, "wr_oor");
    add(1'b0, 1'b1, 32'h0,        32'h0,        32'h11,       1'b1, "no_alias");
    add(1'b0, 1'b1, 32'h40,       32'h0,        32'h0,        1'b1, "rd_oor");
    add(1'b0, 1'b1, 32'h80000000, 32'h0,        32'h0,        1'b1, "rd_oor_msb");
    add(1'b0, 1'b1, 32'h4,        32'h0,        32'h22,       1'b1, "err_sticky");

    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    addr = '0; data_core_mem = '0; we = 1'b0; re = 1'b0;
    step();
    step();
    chk("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rst_load_ready", 32'(load_ready), 32'd0);
    chk("rst_data", data_mem_core, 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // CLEAR: requests outside RUN must be ignored (no err).
    we = 1'b1; re = 1'b1; addr = 32'h40; data_core_mem = 32'hFFFF_FFFF;
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("clear_load_ready", 32'(load_ready), 32'(k == 16));
      chk("clear_core_rst_n", 32'(core_rst_n), 32'd0);
    end
    chk("clear_err", 32'(err), 32'd0);
    chk("clear_data", data_mem_core, 32'd0);
    we = 1'b0; re = 1'b0; addr = '0; data_core_mem = '0;

    // Load 3-word image.
    load_valid = 1'b1; load_data = 32'h11; load_last = 1'b0;
    step();
    chk("load_ready_mid", 32'(load_ready), 32'd1);
    load_data = 32'h22;
    step();
    load_data = 32'h33; load_last = 1'b1;
    step();
    chk("release_load_ready", 32'(load_ready), 32'd0);
    chk("release_core_rst_n", 32'(core_rst_n), 32'd0);
    load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    step();
    chk("run_core_rst_n", 32'(core_rst_n), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr;
      data_core_mem = vecs[i].wdata;
      step();
      chk(vecs[i].nm, data_mem_core, vecs[i].exp_data);
      chk({vecs[i].nm, "_err"}, 32'(err), 32'(vecs[i].exp_err));
    end
    we = 1'b0; re = 1'b0; addr = '0; data_core_mem = '0;

    // Reset during RUN.
    rst_n = 1'b0;
    step();
    chk("rerst_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("rerst_err", 32'(err), 32'd0);
    chk("rerst_data", data_mem_core, 32'd0);
    chk("rerst_load_ready", 32'(load_ready), 32'd0);
    rst_n = 1'b1;
    wait_ready();
    load_valid = 1'b1; load_data = 32'h0; load_last = 1'b1;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    step();
    chk("rerun_core_rst_n", 32'(core_rst_n), 32'd1);
    rd("rerun_w1_cleared", 32'h4, 32'h0);
    rd("rerun_w15_cleared", 32'h3C, 32'h0);
    rd("rerun_w2_cleared", 32'h8, 32'h0);
    rd("rerun_w0", 32'h0, 32'h0);

    // Load overflow: 16 beats with no last.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    wait_ready();
    for (int i = 0; i < 16; i++) begin
      chk("ovf_load_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1; load_data = 32'(i + 1); load_last = 1'b0;
      step();
    end
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_load_ready_off", 32'(load_ready), 32'd0);
    chk("ovf_release", 32'(core_rst_n), 32'd0);
    load_data = 32'h99;
    step();
    chk("ovf_17th_ready", 32'(load_ready), 32'd0);
    chk("ovf_run", 32'(core_rst_n), 32'd1);
    load_valid = 1'b0;
    rd("ovf_rd_w15", 32'h3C, 32'd16);
    rd("ovf_rd_w0", 32'h0, 32'd1);
    chk("ovf_err_sticky", 32'(err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
